// File: rtl/pmod_pkg.sv
// Shared constants and helpers for the PMOD IIC adapter.
// Pin indices map PMOD connector pin numbers onto the 8-bit pin vectors.
package pmod_pkg;

  localparam int unsigned PMOD_PIN1  = 0;
  localparam int unsigned PMOD_PIN2  = 1;
  localparam int unsigned PMOD_PIN3  = 2;
  localparam int unsigned PMOD_PIN4  = 3;
  localparam int unsigned PMOD_PIN7  = 4;
  localparam int unsigned PMOD_PIN8  = 5;
  localparam int unsigned PMOD_PIN9  = 6;
  localparam int unsigned PMOD_PIN10 = 7;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/pmod_sync_filter.sv
// One-bit synchroniser followed by a glitch filter that only accepts a new
// level after FILTER_LEN consecutive differing synced samples.
module pmod_sync_filter
  import pmod_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3,
  parameter bit          RESET_VAL   = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("pmod_sync_filter: SYNC_STAGES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  if (FILTER_LEN == 0) begin : g_bypass
    assign q_o = synced;
  end else begin : g_filter
    localparam int unsigned CntW = clog2(FILTER_LEN + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(FILTER_LEN - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            out_q, out_d;

    // Counter only runs while the synced level disagrees with the output.
    always_comb begin
      out_d = out_q;
      cnt_d = '0;
      if (synced != out_q) begin
        if (cnt_q == CntLast) begin
          out_d = synced;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
        out_q <= RESET_VAL;
      end else begin
        cnt_q <= cnt_d;
        out_q <= out_d;
      end
    end

    assign q_o = out_q;
  end

endmodule

// File: rtl/pmod_iic_port.sv
// PMOD connector to IIC master adapter: pin muxing, filtered inputs,
// sticky interrupt capture and stuck-low SCL detection.
module pmod_iic_port
  import pmod_pkg::*;
#(
  parameter int unsigned SCL_IDX        = PMOD_PIN3,
  parameter int unsigned SDA_IDX        = PMOD_PIN4,
  parameter int unsigned IRQ_IDX        = PMOD_PIN1,
  parameter bit          IRQ_ACTIVE_LOW = 1'b1,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 3,
  parameter bit          OPEN_DRAIN     = 1'b1,
  parameter int unsigned STUCK_CYCLES   = 100000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] pmod_i,
  output logic [7:0] pmod_o,
  output logic [7:0] pmod_t,
  output logic       scl_i,
  input  logic       scl_o,
  input  logic       scl_t,
  output logic       sda_i,
  input  logic       sda_o,
  input  logic       sda_t,
  input  logic       irq_clear,
  output logic       irq,
  output logic       irq_level,
  output logic       bus_stuck
);

  if (SCL_IDX > 7 || SDA_IDX > 7 || IRQ_IDX > 7) begin : g_bad_range
    $error("pmod_iic_port: pin index outside 0..7");
  end
  if (SCL_IDX == SDA_IDX || SCL_IDX == IRQ_IDX || SDA_IDX == IRQ_IDX) begin : g_bad_alias
    $error("pmod_iic_port: SCL_IDX, SDA_IDX and IRQ_IDX must be distinct");
  end
  if (STUCK_CYCLES < 1) begin : g_bad_stuck
    $error("pmod_iic_port: STUCK_CYCLES must be at least 1");
  end

  localparam logic [2:0] SclPin = SCL_IDX[2:0];
  localparam logic [2:0] SdaPin = SDA_IDX[2:0];
  localparam logic [2:0] IrqPin = IRQ_IDX[2:0];

  localparam int unsigned StuckW = clog2(STUCK_CYCLES + 1);
  localparam logic [StuckW-1:0] StuckMax = StuckW'(STUCK_CYCLES);

  logic scl_filt, sda_filt, irq_filt;
  logic unused_pins;

  // Only the three mapped pins feed logic; the rest are inputs by design.
  assign unused_pins = ^pmod_i;

  pmod_sync_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN),
    .RESET_VAL  (1'b1)
  ) u_scl_filter (
    .clk_i (clk),
    .rst_ni(reset_n),
    .d_i   (pmod_i[SclPin]),
    .q_o   (scl_filt)
  );

  pmod_sync_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN),
    .RESET_VAL  (1'b1)
  ) u_sda_filter (
    .clk_i (clk),
    .rst_ni(reset_n),
    .d_i   (pmod_i[SdaPin]),
    .q_o   (sda_filt)
  );

  pmod_sync_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN),
    .RESET_VAL  (1'b1)
  ) u_irq_filter (
    .clk_i (clk),
    .rst_ni(reset_n),
    .d_i   (pmod_i[IrqPin]),
    .q_o   (irq_filt)
  );

  assign scl_i = scl_filt;
  assign sda_i = sda_filt;

  // Open-drain mode never drives high: a '1' from the master just releases.
  always_comb begin
    pmod_o = '0;
    pmod_t = '1;
    if (OPEN_DRAIN) begin
      pmod_t[SclPin] = scl_t | scl_o;
      pmod_t[SdaPin] = sda_t | sda_o;
    end else begin
      pmod_o[SclPin] = scl_o;
      pmod_t[SclPin] = scl_t;
      pmod_o[SdaPin] = sda_o;
      pmod_t[SdaPin] = sda_t;
    end
  end

  logic              level_q;
  logic              irq_q, irq_d;
  logic [StuckW-1:0] stuck_cnt_q, stuck_cnt_d;

  assign irq_level = irq_filt ^ IRQ_ACTIVE_LOW;

  // A new edge outranks a simultaneous clear so no event is lost.
  always_comb begin
    irq_d = irq_q;
    if (irq_level && !level_q) begin
      irq_d = 1'b1;
    end else if (irq_clear) begin
      irq_d = 1'b0;
    end
  end

  always_comb begin
    stuck_cnt_d = stuck_cnt_q;
    if (scl_filt) begin
      stuck_cnt_d = '0;
    end else if (stuck_cnt_q != StuckMax) begin
      stuck_cnt_d = stuck_cnt_q + 1'b1;
    end
  end

  // level_q resets to the idle level so reset release is not seen as an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q     <= 1'b1 ^ IRQ_ACTIVE_LOW;
      irq_q       <= 1'b0;
      stuck_cnt_q <= '0;
    end else begin
      level_q     <= irq_level;
      irq_q       <= irq_d;
      stuck_cnt_q <= stuck_cnt_d;
    end
  end

  assign irq       = irq_q;
  assign bus_stuck = (stuck_cnt_q == StuckMax);

endmodule
